// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the memory arbiter.
//   word_t      - 32-bit data/address word
//   ramstate_t  - RAM handshake state reported by the memory (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t - arbiter FSM state (IDLE, IGRANT, DGRANT)
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: grant-length counter for the memory arbiter.
//   i_clk    - clock
//   i_rst    - asynchronous active-high reset
//   i_clear  - synchronous clear (held while the arbiter is idle)
//   i_enable - count one stalled grant cycle
//   o_tc     - terminal count: counter has reached WAIT_MAX-1
module arb_watchdog #(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int unsigned W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_tc) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_tc = (r_count == W'(WAIT_MAX - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one RAM port between an icache (read-only) and a dcache (read/write).
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on simultaneous requests;
// otherwise the dcache always wins.
//   CLK, RST                     - clock, asynchronous active-high reset
//   iREN, iaddr / iwait, iload   - icache request / stall and read data
//   dREN, dWEN, daddr, dstore    - dcache request, address, write data
//   dwait, dload                 - dcache stall and read data
//   ramREN, ramWEN, ramaddr, ramstore - RAM request
//   ramload, ramstate            - RAM read data and handshake state
//   arb_err                      - one-cycle pulse when the watchdog aborts a grant
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      arb_err
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       w_d_req;
    logic       w_req_active;
    logic       w_access;
    logic       w_done;
    logic       w_tc;
    logic       w_timeout;

    assign w_d_req  = dREN | dWEN;
    assign w_access = (ramstate == ACCESS);

    // Request of whoever currently holds the grant; dropping it ends the grant silently.
    always_comb begin
        w_req_active = 1'b0;
        case (r_state)
            IGRANT:  w_req_active = iREN;
            DGRANT:  w_req_active = w_d_req;
            default: w_req_active = 1'b0;
        endcase
    end

    assign w_done    = w_req_active & w_access;
    assign w_timeout = w_req_active & ~w_access & w_tc;

    arb_watchdog #(
        .WAIT_MAX (WAIT_MAX)
    ) u_watchdog (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_clear  (r_state == IDLE),
        .i_enable (w_req_active & ~w_access),
        .o_tc     (w_tc)
    );

`ifdef MEM_ARB_RR_EN
    logic r_last_d;  // 1: most recent grant went to the dcache
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
`ifdef MEM_ARB_RR_EN
                if (w_d_req && iREN) begin
                    w_next = r_last_d ? IGRANT : DGRANT;
                end else
`endif
                if (w_d_req) begin
                    w_next = DGRANT;
                end else if (iREN) begin
                    w_next = IGRANT;
                end else begin
                    w_next = IDLE;
                end
            end
            IGRANT, DGRANT: begin
                if (!w_req_active || w_done || w_timeout) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last_d <= 1'b0;
        end else if (r_state == IDLE && w_next == DGRANT) begin
            r_last_d <= 1'b1;
        end else if (r_state == IDLE && w_next == IGRANT) begin
            r_last_d <= 1'b0;
        end
    end
`endif

    // RAM-side and cache-side outputs follow the live requester signals of the granted side.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        arb_err  = w_timeout;
        case (r_state)
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (w_done) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (w_done) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized self-checking bench for mem_arbiter (WAIT_MAX=4).
// Follows MEM_ARB_RR_EN in its reference model when the macro is defined.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int unsigned WAIT_MAX = 4;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      iwait, dwait, ramREN, ramWEN, arb_err;
    word_t     iload, dload, ramaddr, ramstore;

    mem_arbiter #(
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .arb_err  (arb_err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the RAM (0 none, 1 icache, 2 dcache) and how long it has waited.
    int m_owner, m_cnt, n_owner, n_cnt;
    bit m_last_d, n_last_d;
    logic  e_ramren, e_ramwen, e_iwait, e_dwait, e_err;
    word_t e_addr, e_store, e_iload, e_dload;

    int obs_iwait0, obs_dwait0, obs_err;
    word_t obs_iload;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_owner  = 0;
        m_cnt    = 0;
        m_last_d = 1'b0;
    endfunction

    function automatic void model_eval();
        bit ireq, dreq, acc, act, done, tout;
        ireq = (iREN === 1'b1);
        dreq = (dREN === 1'b1) || (dWEN === 1'b1);
        acc  = (ramstate == ACCESS);
        e_ramren = 0; e_ramwen = 0; e_addr = 0; e_store = 0;
        e_iwait = 1; e_dwait = 1; e_iload = 0; e_dload = 0; e_err = 0;
        n_owner = m_owner; n_cnt = m_cnt; n_last_d = m_last_d;
        if (m_owner == 0) begin
            if (ireq && dreq) begin
`ifdef MEM_ARB_RR_EN
                n_owner = m_last_d ? 1 : 2;
`else
                n_owner = 2;
`endif
            end else if (dreq) n_owner = 2;
            else if (ireq) n_owner = 1;
            if (n_owner != 0) n_last_d = (n_owner == 2);
            n_cnt = 0;
        end else begin
            act  = (m_owner == 1) ? ireq : dreq;
            done = act && acc;
            tout = act && !acc && (m_cnt == WAIT_MAX - 1);
            e_err = tout;
            if (m_owner == 1) begin
                e_ramren = 1;
                e_addr   = iaddr;
                if (done) begin e_iwait = 0; e_iload = ramload; end
            end else begin
                e_ramwen = dWEN;
                e_ramren = dREN && !dWEN;
                e_addr   = daddr;
                e_store  = dstore;
                if (done) begin e_dwait = 0; e_dload = ramload; end
            end
            if (!act || done || tout) n_owner = 0;
            else n_cnt = m_cnt + 1;
        end
    endfunction

    task automatic check_now();
        model_eval();
        chk("ramREN",   32'(ramREN),   32'(e_ramren));
        chk("ramWEN",   32'(ramWEN),   32'(e_ramwen));
        chk("ramaddr",  ramaddr,       e_addr);
        chk("ramstore", ramstore,      e_store);
        chk("iwait",    32'(iwait),    32'(e_iwait));
        chk("dwait",    32'(dwait),    32'(e_dwait));
        chk("iload",    iload,         e_iload);
        chk("dload",    dload,         e_dload);
        chk("arb_err",  32'(arb_err),  32'(e_err));
    endtask

    // One clock: check outputs mid-cycle, advance the model at the edge, return just after it.
    task automatic tick();
        @(negedge CLK);
        check_now();
        if (iwait === 1'b0) begin obs_iwait0++; obs_iload = iload; end
        if (dwait === 1'b0) obs_dwait0++;
        if (arb_err === 1'b1) obs_err++;
        @(posedge CLK);
        m_owner  = n_owner;
        m_cnt    = n_cnt;
        m_last_d = n_last_d;
        #1;
    endtask

    task automatic clear_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        ramstate = FREE;
    endtask

    task automatic clear_obs();
        obs_iwait0 = 0; obs_dwait0 = 0; obs_err = 0; obs_iload = 0;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must drop without waiting for an edge.
    task automatic mid_cycle_reset();
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_now();
        clear_inputs();
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int r;
        clear_inputs();
        clear_obs();
        model_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_now();
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // icache read, RAM answers on its second cycle
        clear_obs();
        iREN = 1; iaddr = 32'h40; ramstate = BUSY;
        tick();
        tick();
        ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
        tick();
        iREN = 0; ramstate = FREE;
        tick();
        chk("icache_pulse_count", 32'(obs_iwait0), 32'd1);
        chk("icache_load_value", obs_iload, 32'hDEAD_BEEF);

        // simultaneous icache/dcache requests, RAM always ready
        clear_obs();
        iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h100; ramstate = ACCESS;
        ramload = 32'h0BAD_F00D;
        tick();
        tick();
        dREN = 0;
        tick();
        tick();
        iREN = 0;
        tick();
        chk("contention_i_done", 32'(obs_iwait0), 32'd1);
        chk("contention_d_done", 32'(obs_dwait0), 32'd1);

        // dcache write
        clear_obs();
        dWEN = 1; daddr = 32'h80; dstore = 32'h1234; ramstate = BUSY;
        tick();
        tick();
        ramstate = ACCESS;
        tick();
        dWEN = 0; ramstate = FREE;
        tick();
        chk("write_done", 32'(obs_dwait0), 32'd1);

        // RAM stuck busy: watchdog abort on the 4th grant cycle
        clear_obs();
        dREN = 1; daddr = 32'h300; ramstate = BUSY;
        repeat (5) tick();
        dREN = 0;
        tick();
        chk("watchdog_pulses", 32'(obs_err), 32'd1);
        chk("watchdog_no_dwait0", 32'(obs_dwait0), 32'd0);

        // icache drops its request mid-grant
        clear_obs();
        iREN = 1; iaddr = 32'h44; ramstate = BUSY;
        tick();
        tick();
        iREN = 0; ramstate = ACCESS;
        tick();
        tick();
        chk("drop_no_iwait0", 32'(obs_iwait0), 32'd0);

        // reset in the middle of a dcache grant
        dREN = 1; daddr = 32'h500; ramstate = BUSY;
        tick();
        tick();
        mid_cycle_reset();
        tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            iREN   = ($urandom_range(0, 2) != 0);
            dREN   = ($urandom_range(0, 2) == 0);
            dWEN   = ($urandom_range(0, 3) == 0);
            iaddr  = $urandom;
            daddr  = $urandom;
            dstore = $urandom;
            ramload = $urandom;
            r = $urandom_range(0, 9);
            if (r < 3) ramstate = ACCESS;
            else if (r < 7) ramstate = BUSY;
            else if (r < 9) ramstate = FREE;
            else ramstate = ERROR;
            if ($urandom_range(0, 149) == 0) mid_cycle_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have one parameter: WAIT_MAX, default 16, the maximum cycles a grant may wait for RAM before abort.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have ports iREN in 1 (icache read request) and iaddr in 32 (icache word address).
REQ-005 SHALL have ports iwait out 1 (icache stall) and iload out 32 (icache read data).
REQ-006 SHALL have ports dREN in 1 and dWEN in 1 (dcache read/write request), daddr in 32 and dstore in 32 (dcache address/write data).
REQ-007 SHALL have ports dwait out 1 (dcache stall) and dload out 32 (dcache read data).
REQ-008 SHALL have ports ramREN out 1, ramWEN out 1, ramaddr out 32 and ramstore out 32 (RAM request).
REQ-009 SHALL have ports ramload in 32 (RAM data) and ramstate in 2, typed ramstate_t with values FREE, BUSY, ACCESS, ERROR.
REQ-010 SHALL have port arb_err out 1: one-cycle pulse on watchdog abort.

Function
REQ-011 SHALL implement the FSM IDLE, IGRANT, DGRANT; the state is registered.
REQ-012 In IDLE: ramREN=ramWEN=0; iwait=dwait=1; next state DGRANT if dREN|dWEN, else IGRANT if iREN, else IDLE (fixed data priority).
REQ-013 In IGRANT: ramREN=1, ramWEN=0, ramaddr=iaddr; ram outputs are combinational from the live requester signals.
REQ-014 In DGRANT: ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore; dWEN wins if both dREN and dWEN are asserted.
REQ-015 During a grant, ramstate==ACCESS SHALL complete the transfer in that same cycle:
- granted wait=0;
- iload/dload=ramload (combinational);
- next state IDLE.
REQ-016 The non-granted requester's wait SHALL stay 1 at all times; iload/dload SHALL be 0 when not completing.
REQ-017 Granted requester deasserting its request mid-grant SHALL return to IDLE next cycle without a wait=0 pulse.
REQ-018 ramstate FREE, BUSY or ERROR during a grant SHALL hold wait=1 and hold the state.
REQ-019 Watchdog counter SHALL behave as follows:
- clears on entering a grant;
- increments each grant cycle without ACCESS;
- on reaching WAIT_MAX-1, the next state is IDLE and arb_err=1 for that cycle.
REQ-020 Minimum transfer latency SHALL be 2 cycles from request assertion (1 IDLE cycle + 1 ACCESS cycle); back-to-back grants always pass through IDLE.

Reset
REQ-021 RST high SHALL asynchronously force the following:
- state IDLE;
- watchdog 0;
- last-grant register = I;
- ramREN=ramWEN=0, ramaddr=ramstore=0;
- iwait=dwait=1, iload=dload=0, arb_err=0.
REQ-022 Reset asserted mid-grant SHALL abandon the transfer with no completion pulse.

Configuration
REQ-023 With macro MEM_ARB_RR_EN defined, simultaneous requests in IDLE SHALL grant the requester not granted last (round-robin via last-grant register, updated at every grant).
REQ-024 Without MEM_ARB_RR_EN, arbitration SHALL be fixed data priority per REQ-012 and the last-grant register SHALL be absent.

Structure
REQ-025 ramstate_t and arb_state_t (IDLE, IGRANT, DGRANT) SHALL reside in cpu_types_pkg; word_t SHALL be used for all 32-bit fields.
REQ-026 The watchdog SHALL be a sub-module arb_watchdog (clear, enable, terminal-count output, width $clog2(WAIT_MAX)); all other logic stays in mem_arbiter.

Verification
REQ-027 iREN=1, iaddr=0x40, RAM returns ACCESS on its 2nd cycle with ramload=0xDEADBEEF -> IGRANT; iwait=0 and iload=0xDEADBEEF in exactly one cycle; then IDLE.
REQ-028 iREN=dREN=1 together, fixed priority -> DGRANT first, daddr on ramaddr; after completion, IGRANT; iwait=1 throughout DGRANT.
REQ-029 MEM_ARB_RR_EN, last grant D, both requesting -> IGRANT first; repeated contention alternates I,D,I,D.
REQ-030 dWEN=1, daddr=0x80, dstore=0x1234 -> ramWEN=1, ramREN=0, ramstore=0x1234; dwait=0 on ACCESS.
REQ-031 WAIT_MAX=4, ramstate stuck BUSY -> arb_err pulses on the 4th grant cycle; state IDLE; dwait never 0.
REQ-032 iREN drops during IGRANT -> IDLE next cycle with no iwait=0; RST asserted mid-DGRANT -> immediate reset values per REQ-021.
